// File: rtl/mmm_pkg.sv
// rtl/mmm_pkg.sv - shared state type and timing constant for the Montgomery multiply controller
package mmm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ITER,
    S_FINAL,
    S_DONE
  } mmm_state_t;

  // CLR + FINAL + DONE cycles added on top of the N iterations
  localparam int unsigned MMM_OVERHEAD = 3;

endpackage

// File: rtl/mmm_iter_cnt.sv
// rtl/mmm_iter_cnt.sv - iteration counter holding the latched count, current index and terminal flag
module mmm_iter_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_limit,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_idx,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_limit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_limit <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_limit <= i_limit;
        r_idx   <= '0;
      end else if (i_clr) begin
        r_idx <= '0;
      end else if (i_inc && !o_tc) begin
        r_idx <= r_idx + CNT_W'(1);
      end
    end
  end

  // Index saturates at limit-1 so the final load still reports the last bit
  assign o_tc  = (r_idx == (r_limit - CNT_W'(1)));
  assign o_idx = r_idx;

endmodule

// File: rtl/mmm_ctrl.sv
// rtl/mmm_ctrl.sv - Montgomery multiply sequencing FSM; MMM_CTRL_ABORT_EN adds the abort input
module mmm_ctrl
  import mmm_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] nbits,
`ifdef MMM_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             rst_mmm_o,
  output logic             ld_r,
  output logic             lock,
  output logic [CNT_W-1:0] bit_idx
);

  mmm_state_t       r_state;
  mmm_state_t       w_state_nxt;
  logic             r_busy, r_done, r_rstm, r_ld, r_lock;
  logic             w_busy_nxt, w_done_nxt, w_rstm_nxt, w_ld_nxt, w_lock_nxt;
  logic             w_load, w_inc, w_clr, w_tc, w_abort;
  logic [CNT_W-1:0] w_nbits_sat;
  logic [CNT_W-1:0] w_idx;

  // Zero or oversize requests run the full operand width
  assign w_nbits_sat = ((nbits == '0) || (nbits > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : nbits;

`ifdef MMM_CTRL_ABORT_EN
  assign w_abort = abort && ((r_state == S_CLR) || (r_state == S_ITER) || (r_state == S_FINAL));
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_inc       = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CLR;
          w_load      = 1'b1;
        end
      end
      S_CLR:   w_state_nxt = S_ITER;
      S_ITER: begin
        if (w_tc) w_state_nxt = S_FINAL;
        else      w_inc       = 1'b1;
      end
      S_FINAL: begin
        w_state_nxt = S_DONE;
        w_clr       = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_inc       = 1'b0;
      w_clr       = 1'b1;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_ld_nxt   = (w_state_nxt == S_ITER) || (w_state_nxt == S_FINAL);
    w_lock_nxt = (w_state_nxt == S_FINAL);
    // Datapath clear pulses on entry to CLR and on the abort cycle
    w_rstm_nxt = !((w_state_nxt == S_CLR) || w_abort);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rstm  <= 1'b1;
      r_ld    <= 1'b0;
      r_lock  <= 1'b0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rstm  <= w_rstm_nxt;
      r_ld    <= w_ld_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  mmm_iter_cnt #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (en),
    .i_load  (w_load),
    .i_limit (w_nbits_sat),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .o_idx   (w_idx),
    .o_tc    (w_tc)
  );

  assign busy      = r_busy;
  assign done      = r_done;
  assign rst_mmm_o = r_rstm;
  assign ld_r      = r_ld;
  assign lock      = r_lock;
  assign bit_idx   = w_idx;

endmodule

// File: tb/tb_mmm_ctrl.sv
// tb/tb_mmm_ctrl.sv - bench for mmm_ctrl: offset-based reference model, directed timelines, random traffic
module tb_mmm_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef MMM_CTRL_ABORT_EN
  localparam bit HAS_ABORT = 1'b1;
`else
  localparam bit HAS_ABORT = 1'b0;
`endif

  typedef logic [15:0]       vec_t;
  typedef logic [15:0][2:0]  idxv_t;

  logic             clk = 1'b0;
  logic             rst, en, start, abort;
  logic [CNT_W-1:0] nbits;
  logic             busy, done, rst_mmm_o, ld_r, lock;
  logic [CNT_W-1:0] bit_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmm_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .nbits     (nbits),
`ifdef MMM_CTRL_ABORT_EN
    .abort     (abort),
`endif
    .busy      (busy),
    .done      (done),
    .rst_mmm_o (rst_mmm_o),
    .ld_r      (ld_r),
    .lock      (lock),
    .bit_idx   (bit_idx)
  );

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, c, act, exp);
    end
  endtask

  // Model: an accepted operation is tracked only by how many enabled cycles have passed since start (k)
  bit m_active = 1'b0;
  bit m_abp    = 1'b0;
  int m_k      = 0;
  int m_n      = 0;
  bit chk_on   = 1'b0;
  int ncyc     = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_k = 0; m_n = 0; m_abp = 1'b0; chk_on = 1'b1;
    end else if (en) begin
      m_abp = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_k      = 1;
          m_n      = (nbits == 0 || int'(nbits) > WIDTH) ? WIDTH : int'(nbits);
        end
      end else if (HAS_ABORT && abort && m_k <= m_n + 2) begin
        m_active = 1'b0; m_k = 0; m_abp = 1'b1;
      end else if (m_k == m_n + 3) begin
        m_active = 1'b0; m_k = 0;
      end else begin
        m_k++;
      end
    end
  end

  bit e_busy, e_done, e_ld, e_lock, e_rstm;
  int e_idx;

  always @(negedge clk) begin
    if (chk_on) begin
      ncyc++;
      e_busy = m_active;
      e_done = m_active && (m_k == m_n + 3);
      e_ld   = m_active && (m_k >= 2) && (m_k <= m_n + 2);
      e_lock = m_active && (m_k == m_n + 2);
      e_rstm = !((m_active && m_k == 1) || m_abp);
      e_idx  = e_ld ? (((m_k - 2) < (m_n - 1)) ? (m_k - 2) : (m_n - 1)) : 0;
      chk("model busy",      ncyc, busy,      e_busy);
      chk("model done",      ncyc, done,      e_done);
      chk("model ld_r",      ncyc, ld_r,      e_ld);
      chk("model lock",      ncyc, lock,      e_lock);
      chk("model rst_mmm_o", ncyc, rst_mmm_o, e_rstm);
      chk("model bit_idx",   ncyc, bit_idx,   e_idx);
      chk("lock_implies_ld", ncyc, lock && !ld_r, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bit c of each vector is the input applied during cycle c / the output seen during cycle c
  task automatic run_dir(input string nm, input int nb, input vec_t st, input vec_t enm,
                         input vec_t rsm, input vec_t abm, input int n,
                         input vec_t eb, input vec_t ed, input vec_t erl, input vec_t el,
                         input vec_t elk, input vec_t imask, input idxv_t ei);
    for (int c = 0; c < n; c++) begin
      start = st[c]; en = enm[c]; rst = rsm[c]; abort = abm[c]; nbits = CNT_W'(nb);
      tick();
      chk({nm, " busy"},      c + 1, busy,      eb[c+1]);
      chk({nm, " done"},      c + 1, done,      ed[c+1]);
      chk({nm, " rst_mmm_o"}, c + 1, rst_mmm_o, !erl[c+1]);
      chk({nm, " ld_r"},      c + 1, ld_r,      el[c+1]);
      chk({nm, " lock"},      c + 1, lock,      elk[c+1]);
      if (imask[c+1]) chk({nm, " bit_idx"}, c + 1, bit_idx, ei[c+1]);
    end
    start = 1'b0; rst = 1'b0; abort = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  idxv_t ei4, ei1, eien, eirst;

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b1; abort = 1'b1; nbits = '0;
    tick();
    tick();
    chk("reset busy",      0, busy,      0);
    chk("reset done",      0, done,      0);
    chk("reset ld_r",      0, ld_r,      0);
    chk("reset lock",      0, lock,      0);
    chk("reset bit_idx",   0, bit_idx,   0);
    chk("reset rst_mmm_o", 0, rst_mmm_o, 1);
    rst = 1'b0; en = 1'b1; start = 1'b0; abort = 1'b0;
    tick();

    ei4 = '0;   ei4[3] = 3'd1; ei4[4] = 3'd2; ei4[5] = 3'd3; ei4[6] = 3'd3;
    ei1 = '0;
    eien = '0;  eien[3] = 3'd1; eien[4] = 3'd1; eien[5] = 3'd1; eien[6] = 3'd1;
    eien[7] = 3'd2; eien[8] = 3'd3; eien[9] = 3'd3;
    eirst = '0; eirst[3] = 3'd1; eirst[4] = 3'd2;

    run_dir("n4", 4, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 9,
            16'h00FE, 16'h0080, 16'h0002, 16'h007C, 16'h0040, 16'h007C, ei4);
    run_dir("n0", 0, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 9,
            16'h00FE, 16'h0080, 16'h0002, 16'h007C, 16'h0040, 16'h007C, ei4);
    run_dir("n7", 7, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 9,
            16'h00FE, 16'h0080, 16'h0002, 16'h007C, 16'h0040, 16'h007C, ei4);
    run_dir("n1", 1, 16'h0025, 16'hFFFF, 16'h0000, 16'h0000, 8,
            16'h01DE, 16'h0010, 16'h0042, 16'h018C, 16'h0108, 16'h018C, ei1);
    run_dir("en_hold", 4, 16'h0001, 16'hFFC7, 16'h0000, 16'h0000, 11,
            16'h07FE, 16'h0400, 16'h0002, 16'h03FC, 16'h0200, 16'h03FC, eien);
    run_dir("mid_rst", 4, 16'h0001, 16'hFFFF, 16'h0010, 16'h0000, 12,
            16'h001E, 16'h0000, 16'h0002, 16'h001C, 16'h0000, 16'h003C, eirst);
`ifdef MMM_CTRL_ABORT_EN
    run_dir("abort", 4, 16'h0001, 16'hFFFF, 16'h0000, 16'h0010, 8,
            16'h001E, 16'h0000, 16'h0022, 16'h001C, 16'h0000, 16'h003C, eirst);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      en    = ($urandom_range(0, 99) < 85);
      start = ($urandom_range(0, 99) < 30);
      abort = ($urandom_range(0, 99) < 4);
      nbits = CNT_W'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
